// File: rtl/addsub_sequencer.sv
// addsub_sequencer: three-state add/subtract accumulator sequencer.
// A start in IDLE loads the accumulator. RUN then accepts one add or
// subtract per cycle until an operation arrives with in_last set.
// DONE lasts exactly one cycle and pulses done.
// Optional feature macro: ADDSUB_SATURATE_EN. When it is defined, an
// invalid add clamps acc to all-ones and an invalid subtract clamps
// acc to zero. When it is undefined, acc takes the wrapped result.
module addsub_sequencer #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] init_data,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             in_sub,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_last,
   output logic [WIDTH-1:0] acc,
   output logic             op_strobe,
   output logic             op_ok,
   output logic             err,
   output logic [7:0]       op_count,
   output logic             busy,
   output logic             done
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic             err_q, err_d;
   logic [7:0]       op_count_q, op_count_d;
   logic             op_strobe_q, op_strobe_d;
   logic             op_ok_q, op_ok_d;

   logic [WIDTH:0]   sum;
   logic [WIDTH-1:0] operand;
   logic             carry;
   logic             valid;
   logic             accept;

   // Datapath: subtract is computed as acc + ~in_data + 1 at WIDTH+1 bits.
   always_comb begin
      operand = in_sub ? ~in_data : in_data;
      sum     = {1'b0, acc_q} + {1'b0, operand} + {{WIDTH{1'b0}}, in_sub};
      carry   = sum[WIDTH];
      // An add is valid without carry-out; a subtract is valid with one (no borrow).
      valid   = in_sub ? carry : ~carry;
   end

   // Next-state logic, handshake, and accumulator, error and count update.
   always_comb begin
      state_d     = state_q;
      acc_d       = acc_q;
      err_d       = err_q;
      op_count_d  = op_count_q;
      op_strobe_d = 1'b0;
      op_ok_d     = op_ok_q;
      in_ready    = 1'b0;
      accept      = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               acc_d      = init_data;
               err_d      = 1'b0;
               op_count_d = '0;
               state_d    = RUN;
            end
         end
         RUN: begin
            in_ready = 1'b1;
            accept   = in_valid;
            if (accept) begin
`ifdef ADDSUB_SATURATE_EN
               if (valid)
                  acc_d = sum[WIDTH-1:0];
               else if (in_sub)
                  acc_d = '0;
               else
                  acc_d = '1;
`else
               acc_d = sum[WIDTH-1:0];
`endif
               op_strobe_d = 1'b1;
               op_ok_d     = valid;
               err_d       = err_q | ~valid;
               if (op_count_q != 8'hFF)
                  op_count_d = op_count_q + 8'd1;
               if (in_last)
                  state_d = DONE;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and datapath registers. Reset wins over any start or handshake.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         acc_q       <= '0;
         err_q       <= 1'b0;
         op_count_q  <= '0;
         op_strobe_q <= 1'b0;
         op_ok_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         acc_q       <= acc_d;
         err_q       <= err_d;
         op_count_q  <= op_count_d;
         op_strobe_q <= op_strobe_d;
         op_ok_q     <= op_ok_d;
      end
   end

   // Drive the output ports from the registered state.
   always_comb begin
      acc       = acc_q;
      err       = err_q;
      op_count  = op_count_q;
      op_strobe = op_strobe_q;
      op_ok     = op_ok_q;
      busy      = (state_q != IDLE);
      done      = (state_q == DONE);
   end

endmodule

// File: tb/tb_addsub_sequencer.sv
// Directed self-checking bench for addsub_sequencer at WIDTH=8.
// Expected accumulator values follow ADDSUB_SATURATE_EN when it is defined.
module tb_addsub_sequencer;

   logic       clk = 1'b0;
   logic       reset, start, in_valid, in_sub, in_last;
   logic [7:0] init_data, in_data;
   logic       in_ready, op_strobe, op_ok, err, busy, done;
   logic [7:0] acc, op_count;

   int unsigned total  = 0;
   int unsigned passed = 0;
   int unsigned failed = 0;

   addsub_sequencer #(.WIDTH(8)) dut (
      .clk(clk), .reset(reset), .start(start), .init_data(init_data),
      .in_valid(in_valid), .in_ready(in_ready), .in_sub(in_sub),
      .in_data(in_data), .in_last(in_last), .acc(acc),
      .op_strobe(op_strobe), .op_ok(op_ok), .err(err),
      .op_count(op_count), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   // Advance one rising edge and settle 1 time unit after it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         failed++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; init_data = '0; in_valid = 1'b0;
      in_sub = 1'b0; in_data = '0; in_last = 1'b0;
      tick(); tick();
      check("rst_acc", acc, 0);
      check("rst_in_ready", in_ready, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_count", op_count, 0);
      check("rst_strobe", op_strobe, 0);
      check("rst_err", err, 0);
      reset = 1'b0;

      // Sequence: init 10, add 20, sub 5 marked last.
      start = 1'b1; init_data = 8'd10; tick(); start = 1'b0;
      check("s1_load_acc", acc, 10);
      check("s1_in_ready", in_ready, 1);
      check("s1_busy", busy, 1);
      tick();
      check("s1_idle_rdy_strobe", op_strobe, 0);
      check("s1_idle_rdy_acc", acc, 10);
      in_valid = 1'b1; in_sub = 1'b0; in_data = 8'd20; in_last = 1'b0; tick();
      check("s1_add_acc", acc, 30);
      check("s1_add_strobe", op_strobe, 1);
      check("s1_add_ok", op_ok, 1);
      check("s1_add_count", op_count, 1);
      in_sub = 1'b1; in_data = 8'd5; in_last = 1'b1; tick();
      check("s1_sub_acc", acc, 25);
      check("s1_sub_ok", op_ok, 1);
      check("s1_err", err, 0);
      check("s1_count", op_count, 2);
      check("s1_done", done, 1);
      check("s1_done_rdy", in_ready, 0);
      in_sub = 1'b0; in_data = 8'd99; in_last = 1'b0; tick();
      check("s1_idle_done", done, 0);
      check("s1_idle_busy", busy, 0);
      check("s1_ignore_done_acc", acc, 25);
      check("s1_ignore_done_cnt", op_count, 2);
      check("s1_idle_strobe", op_strobe, 0);
      tick();
      check("s1_ignore_idle_acc", acc, 25);
      check("s1_ignore_idle_cnt", op_count, 2);
      in_valid = 1'b0;

      // Invalid add: 250 + 10 produces a carry-out.
      start = 1'b1; init_data = 8'd250; tick(); start = 1'b0;
      in_valid = 1'b1; in_sub = 1'b0; in_data = 8'd10; in_last = 1'b1; tick();
`ifdef ADDSUB_SATURATE_EN
      check("ovf_acc", acc, 255);
`else
      check("ovf_acc", acc, 4);
`endif
      check("ovf_ok", op_ok, 0);
      check("ovf_err", err, 1);
      check("ovf_done", done, 1);
      in_valid = 1'b0; in_last = 1'b0; tick();
      check("ovf_err_hold", err, 1);

      // Invalid subtract: 5 - 6 borrows, then an add 1 leaves err set.
      start = 1'b1; init_data = 8'd5; tick(); start = 1'b0;
      check("udf_err_clr", err, 0);
      in_valid = 1'b1; in_sub = 1'b1; in_data = 8'd6; tick();
`ifdef ADDSUB_SATURATE_EN
      check("udf_acc", acc, 0);
`else
      check("udf_acc", acc, 255);
`endif
      check("udf_ok", op_ok, 0);
      check("udf_err", err, 1);
      in_sub = 1'b0; in_data = 8'd1; in_last = 1'b1; tick();
`ifdef ADDSUB_SATURATE_EN
      check("udf_add_acc", acc, 1);
      check("udf_add_ok", op_ok, 1);
`else
      check("udf_add_acc", acc, 0);
      check("udf_add_ok", op_ok, 0);
`endif
      check("udf_err_sticky", err, 1);
      in_valid = 1'b0; in_last = 1'b0; tick();

      // Boundaries: 0 - 0 and 255 + 0 are both valid.
      start = 1'b1; init_data = 8'd0; tick(); start = 1'b0;
      in_valid = 1'b1; in_sub = 1'b1; in_data = 8'd0; in_last = 1'b1; tick();
      check("b0_acc", acc, 0);
      check("b0_ok", op_ok, 1);
      in_valid = 1'b0; in_last = 1'b0; tick();
      start = 1'b1; init_data = 8'd255; tick(); start = 1'b0;
      in_valid = 1'b1; in_sub = 1'b0; in_data = 8'd0; in_last = 1'b1; tick();
      check("b255_acc", acc, 255);
      check("b255_ok", op_ok, 1);
      check("b255_err", err, 0);
      in_valid = 1'b0; in_last = 1'b0; tick();

      // Start ignored in RUN, then reset lands mid-sequence after 3 operations.
      start = 1'b1; init_data = 8'd7; tick();
      init_data = 8'd100;
      in_valid = 1'b1; in_sub = 1'b0; in_data = 8'd1; tick();
      start = 1'b0;
      check("run_start_ignored", acc, 8);
      check("run_count1", op_count, 1);
      tick(); tick();
      check("run_acc3", acc, 10);
      check("run_count3", op_count, 3);
      reset = 1'b1; tick();
      check("mid_rst_acc", acc, 0);
      check("mid_rst_count", op_count, 0);
      check("mid_rst_rdy", in_ready, 0);
      check("mid_rst_done", done, 0);
      check("mid_rst_strobe", op_strobe, 0);
      reset = 1'b0; tick();
      check("mid_rst_no_done", done, 0);
      check("mid_rst_idle", busy, 0);

      // 300 back-to-back operations saturate op_count at 255.
      in_valid = 1'b0;
      start = 1'b1; init_data = 8'd3; tick(); start = 1'b0;
      in_valid = 1'b1; in_sub = 1'b0; in_data = 8'd0; in_last = 1'b0;
      for (int i = 0; i < 254; i++) tick();
      check("sat_count254", op_count, 254);
      tick();
      check("sat_count255", op_count, 255);
      for (int i = 0; i < 45; i++) tick();
      check("sat_count300", op_count, 255);
      check("sat_acc", acc, 3);
      check("sat_strobe", op_strobe, 1);
      in_last = 1'b1; tick();
      check("sat_done", done, 1);
      check("sat_count_last", op_count, 255);
      in_valid = 1'b0; in_last = 1'b0; tick();
      check("sat_idle", busy, 0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
